// File: rtl/stage_database_writer.sv
// ============================================================================
// stage_database_writer
//
// Purpose
//   Loads one cascade stage into the stage memory. A stage is
//   NUM_CLASSIFIERS_STAGE trees of NUM_PARAM_PER_CLASSIFIER words each,
//   followed by NUM_STAGE_THRESHOLD threshold words. Every accepted word
//   (i_valid && o_ready) is written exactly one cycle later at the next
//   sequential address. Address 0 holds the first word.
//
//   The word value DEFAULT_VALUE (1010) is reserved as the stage terminator.
//   If it shows up in the incoming data, the writer raises the sticky o_error
//   flag, but it still writes the word. A start request that arrives while the
//   writer is busy also raises o_error and is otherwise ignored.
//
// Optional feature
//   STAGE_WRITER_TERMINATOR_EN : when this macro is defined, the TERM state
//   writes DEFAULT_VALUE at address SIZE_STAGE. That write appears on the
//   write port in the cycle after TERM, together with o_done. When the macro
//   is undefined, TERM performs no write. In both builds o_done follows TERM
//   by one cycle.
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-high reset
//   i_start       in   one-cycle request to load a stage
//   i_valid       in   i_data holds a word
//   i_data        in   [DATA_WIDTH]  incoming stage word
//   o_ready       out  writer accepts a word this cycle
//   o_wr_en       out  memory write strobe
//   o_wr_addr     out  [ADDR_WIDTH] memory write address
//   o_wr_data     out  [DATA_WIDTH] memory write data
//   o_index_tree  out  [12] tree currently being filled
//   o_index_leaf  out  [12] word index within the tree (or threshold index)
//   o_busy        out  high in every state except IDLE
//   o_done        out  one-cycle completion pulse
//   o_error       out  sticky protocol-error flag
// ============================================================================
module stage_database_writer #(
    parameter int ADDR_WIDTH               = 10,
    parameter int DATA_WIDTH               = 16,
    parameter int NUM_CLASSIFIERS_STAGE    = 10,
    parameter int NUM_PARAM_PER_CLASSIFIER = 19,
    parameter int NUM_STAGE_THRESHOLD      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [11:0]           o_index_tree,
    output logic [11:0]           o_index_leaf,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int SIZE_STAGE    = NUM_CLASSIFIERS_STAGE * NUM_PARAM_PER_CLASSIFIER
                                   + NUM_STAGE_THRESHOLD;
    localparam int DEFAULT_VALUE = 1010;

    localparam logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'(DEFAULT_VALUE);
    localparam logic [ADDR_WIDTH-1:0] TERM_ADDR    = ADDR_WIDTH'(SIZE_STAGE);
    localparam logic [11:0]           LAST_TREE    = 12'(NUM_CLASSIFIERS_STAGE - 1);
    localparam logic [11:0]           LAST_LEAF    = 12'(NUM_PARAM_PER_CLASSIFIER - 1);
    localparam logic [11:0]           LAST_THRESH  = 12'(NUM_STAGE_THRESHOLD - 1);

`ifdef STAGE_WRITER_TERMINATOR_EN
    localparam bit TERM_WRITE_EN = 1'b1;
`else
    localparam bit TERM_WRITE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD_TREES,
        LOAD_THRESH,
        TERM,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic                  accept;
    logic                  term_wr;
    logic                  start_ok;
    logic                  start_err;
    logic [ADDR_WIDTH-1:0] word_cnt;

    // Write stage registers: these hold the word that was accepted in the
    // previous cycle.
    logic                  wr_vld_p1;
    logic [ADDR_WIDTH-1:0] wr_addr_p1;
    logic [DATA_WIDTH-1:0] wr_data_p1;

    assign accept    = i_valid && o_ready;
    assign start_ok  = i_start && (state == IDLE);
    assign start_err = i_start && (state != IDLE);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_busy     = 1'b1;
        o_done     = 1'b0;
        term_wr    = 1'b0;

        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_next = LOAD_TREES;
                end
            end

            LOAD_TREES: begin
                o_ready = 1'b1;
                if (accept && (o_index_tree == LAST_TREE)
                           && (o_index_leaf == LAST_LEAF)) begin
                    state_next = LOAD_THRESH;
                end
            end

            LOAD_THRESH: begin
                o_ready = 1'b1;
                if (accept && (o_index_leaf == LAST_THRESH)) begin
                    state_next = TERM;
                end
            end

            TERM: begin
                term_wr    = TERM_WRITE_EN;
                state_next = DONE;
            end

            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accept stage: word counter, tree/leaf indices, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt     <= '0;
            o_index_tree <= '0;
            o_index_leaf <= '0;
            o_error      <= 1'b0;
        end else if (start_ok) begin
            word_cnt     <= '0;
            o_index_tree <= '0;
            o_index_leaf <= '0;
            o_error      <= 1'b0;
        end else begin
            if (start_err) begin
                o_error <= 1'b1;
            end

            if (accept) begin
                word_cnt <= word_cnt + 1'b1;

                // The reserved terminator value inside the payload is flagged,
                // but the word is still stored.
                if (i_data == DEFAULT_WORD) begin
                    o_error <= 1'b1;
                end

                if (state == LOAD_TREES) begin
                    if (o_index_leaf == LAST_LEAF) begin
                        o_index_leaf <= '0;
                        // On the last tree, the index stays at the final tree
                        // while the threshold words load.
                        if (o_index_tree != LAST_TREE) begin
                            o_index_tree <= o_index_tree + 1'b1;
                        end
                    end else begin
                        o_index_leaf <= o_index_leaf + 1'b1;
                    end
                end else begin
                    // Threshold words: the last index holds so that the
                    // value still reads as a valid threshold slot.
                    if (o_index_leaf != LAST_THRESH) begin
                        o_index_leaf <= o_index_leaf + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Write stage (p1): one-cycle latency from accept to memory write
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_vld_p1 <= accept || term_wr;
            if (accept) begin
                wr_addr_p1 <= word_cnt;
                wr_data_p1 <= i_data;
            end else if (term_wr) begin
                wr_addr_p1 <= TERM_ADDR;
                wr_data_p1 <= DEFAULT_WORD;
            end
        end
    end

    assign o_wr_en   = wr_vld_p1;
    assign o_wr_addr = wr_addr_p1;
    assign o_wr_data = wr_data_p1;

endmodule

// File: tb/tb_stage_database_writer.sv
module tb_stage_database_writer;

    localparam int AW   = 10;
    localparam int DW   = 16;
    localparam int NC   = 10;
    localparam int NP   = 19;
    localparam int NT   = 3;
    localparam int SIZE = NC * NP + NT;
    localparam int DEF  = 1010;
    localparam int MAX_CYC = 4000;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_ready;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic [11:0]   o_index_tree;
    logic [11:0]   o_index_leaf;
    logic          o_busy;
    logic          o_done;
    logic          o_error;

    int errors = 0;
    int checks = 0;
    bit m_err;

    always #5 clk = ~clk;

    stage_database_writer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_CLASSIFIERS_STAGE(NC),
        .NUM_PARAM_PER_CLASSIFIER(NP),
        .NUM_STAGE_THRESHOLD(NT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_start(i_start),
        .i_valid(i_valid),
        .i_data(i_data),
        .o_ready(o_ready),
        .o_wr_en(o_wr_en),
        .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data),
        .o_index_tree(o_index_tree),
        .o_index_leaf(o_index_leaf),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_error(o_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = DW'($urandom_range(0, 65535));
        if (w == DW'(DEF)) w = DW'(DEF + 1);
        return w;
    endfunction

    // Drives one stage load and checks every cycle against the model.
    // The model tracks k = number of accepted words. Write address = k at
    // accept. Tree/leaf come from k by division (trees) or by subtraction
    // (thresholds).
    // vmode: 0 continuous valid, 1 every other cycle, 2 random.
    // dmode: 0 data = position, 1 random data.
    task automatic load_stage(input int vmode, input int dmode, input int bad_pos,
                              input int busy_at, input int abort_at,
                              input bit start_in_done);
        int            k;
        int            cyc;
        int            exp_tree;
        int            exp_leaf;
        bit            v;
        bit            st;
        logic [DW-1:0] d;

        i_start = 1'b1;
        i_valid = 1'b0;
        step();
        i_start = 1'b0;
        m_err   = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_ready !== 1'b1 || o_error !== 1'b0 ||
            o_index_tree !== 12'd0 || o_index_leaf !== 12'd0 || o_wr_en !== 1'b0)
            begin
            errors++;
            $display("FAIL start_state: busy=%b ready=%b err=%b tree=%0d leaf=%0d wr=%b, required 1 1 0 0 0 0",
                     o_busy, o_ready, o_error, o_index_tree, o_index_leaf, o_wr_en);
        end

        k   = 0;
        cyc = 0;
        while (k < SIZE && cyc < MAX_CYC) begin
            if (abort_at >= 0 && k == abort_at) return;
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (k == bad_pos)   d = DW'(DEF);
            else if (dmode == 0) d = DW'(k);
            else                 d = rand_word();
            st      = (k == busy_at);
            i_valid = v;
            i_data  = d;
            i_start = st;
            step();
            cyc++;
            if (st) m_err = 1'b1;
            if (v && d == DW'(DEF)) m_err = 1'b1;

            checks++;
            if (o_wr_en !== v) begin
                errors++;
                $display("FAIL wr_en k=%0d: got %b required %b", k, o_wr_en, v);
            end
            if (v) begin
                checks++;
                if (o_wr_addr !== AW'(k) || o_wr_data !== d) begin
                    errors++;
                    $display("FAIL write k=%0d: got addr=%0d data=%0d required addr=%0d data=%0d",
                             k, o_wr_addr, o_wr_data, k, d);
                end
                k++;
            end

            checks++;
            if (o_ready !== (k < SIZE) || o_done !== 1'b0 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL ctrl k=%0d: got ready=%b done=%b busy=%b required %b 0 1",
                         k, o_ready, o_done, o_busy, (k < SIZE));
            end

            if (k < SIZE) begin
                if (k < NC * NP) begin
                    exp_tree = k / NP;
                    exp_leaf = k % NP;
                end else begin
                    exp_tree = NC - 1;
                    exp_leaf = k - NC * NP;
                end
                checks++;
                if (o_index_tree !== 12'(exp_tree) || o_index_leaf !== 12'(exp_leaf)) begin
                    errors++;
                    $display("FAIL index k=%0d: got tree=%0d leaf=%0d required tree=%0d leaf=%0d",
                             k, o_index_tree, o_index_leaf, exp_tree, exp_leaf);
                end
            end

            checks++;
            if (o_error !== m_err) begin
                errors++;
                $display("FAIL error k=%0d: got %b required %b", k, o_error, m_err);
            end
        end
        i_valid = 1'b0;
        i_start = 1'b0;

        checks++;
        if (cyc >= MAX_CYC) begin
            errors++;
            $display("FAIL load_timeout: got %0d words required %0d", k, SIZE);
            return;
        end

        // TERM -> DONE
        step();
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b ready=%b required 1 1 0",
                     o_done, o_busy, o_ready);
        end
`ifdef STAGE_WRITER_TERMINATOR_EN
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== AW'(SIZE) || o_wr_data !== DW'(DEF)) begin
            errors++;
            $display("FAIL terminator: got wr=%b addr=%0d data=%0d required 1 %0d %0d",
                     o_wr_en, o_wr_addr, o_wr_data, SIZE, DEF);
        end
`else
        checks++;
        if (o_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL no_terminator: got wr=%b addr=%0d required wr=0", o_wr_en, o_wr_addr);
        end
`endif

        // DONE -> IDLE, optionally with a start in the DONE cycle
        i_start = start_in_done;
        step();
        i_start = 1'b0;
        if (start_in_done) m_err = 1'b1;
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_wr_en !== 1'b0 ||
            o_ready !== 1'b0 || o_error !== m_err || o_index_tree !== 12'(NC - 1)) begin
            errors++;
            $display("FAIL idle_after: got done=%b busy=%b wr=%b ready=%b err=%b tree=%0d required 0 0 0 0 %b %0d",
                     o_done, o_busy, o_wr_en, o_ready, o_error, o_index_tree, m_err, NC - 1);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        i_start = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        step();
        step();
        checks++;
        if (o_ready !== 1'b0 || o_wr_en !== 1'b0 || o_wr_addr !== '0 || o_wr_data !== '0 ||
            o_index_tree !== '0 || o_index_leaf !== '0 || o_busy !== 1'b0 ||
            o_done !== 1'b0 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b wr=%b addr=%0d data=%0d busy=%b done=%b err=%b required all 0",
                     o_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_error);
        end
        reset = 1'b0;
        // valid without a start is ignored
        i_valid = 1'b1;
        i_data  = DW'(16'h1234);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (o_wr_en !== 1'b0 || o_ready !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid: got wr=%b ready=%b busy=%b required 0 0 0",
                         o_wr_en, o_ready, o_busy);
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic test_continuous();
        load_stage(0, 0, -1, -1, -1, 1'b0);
    endtask

    task automatic test_toggle();
        load_stage(1, 0, -1, -1, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) load_stage(2, 1, -1, -1, -1, 1'b0);
    endtask

    task automatic test_bad_word();
        load_stage(0, 0, 5, -1, -1, 1'b0);
        step();
        checks++;
        if (o_error !== 1'b1) begin
            errors++;
            $display("FAIL bad_word_sticky: got %b required 1", o_error);
        end
        // the next start clears the flag (checked by start_state)
        load_stage(2, 1, -1, -1, -1, 1'b0);
    endtask

    task automatic test_busy_start();
        load_stage(2, 1, -1, 40, -1, 1'b1);
        step();
        checks++;
        if (o_error !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_sticky: got err=%b busy=%b required 1 0", o_error, o_busy);
        end
    endtask

    task automatic test_reset_abort();
        load_stage(0, 1, -1, -1, 100, 1'b0);
        i_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b0 || o_wr_en !== 1'b0 || o_wr_addr !== '0 || o_wr_data !== '0 ||
            o_index_tree !== '0 || o_index_leaf !== '0 || o_busy !== 1'b0 ||
            o_done !== 1'b0 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got ready=%b wr=%b addr=%0d tree=%0d leaf=%0d busy=%b required all 0",
                     o_ready, o_wr_en, o_wr_addr, o_index_tree, o_index_leaf, o_busy);
        end
        step();
        reset   = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (o_wr_en !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_write: got wr=%b busy=%b required 0 0", o_wr_en, o_busy);
            end
        end
        i_valid = 1'b0;
        load_stage(2, 1, -1, -1, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_toggle();
        test_random();
        test_bad_word();
        test_busy_start();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
